uut_1_fcs_ctl: RTL and testbench

//  Frame sequencer for the FCS check datapath. Accepts a byte stream with valid/ready handshake and
//  sof/eof framing, and drives registered byte/sof/eof/strobe into the byte packer + CRC checker.

---
 rtl/uut_1_fcs_ctl.sv | 215 +++++++++++++++++++++
 tb/tb_uut_1_fcs_ctl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uut_1_fcs_ctl.sv
// Frame sequencer for the FCS check datapath: forwards framed bytes, waits for the checker verdict.
// Optional FCS_CTL_STATS_EN builds the frame/bad-frame counters (tied to 0 otherwise).
module uut_1_fcs_ctl #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int TMO     = 15,
  parameter int LEN_W   = 16
) (
  input  logic             pclk_i,
  input  logic             rstn_i,
  input  logic [7:0]       s_data_i,
  input  logic             s_sof_i,
  input  logic             s_eof_i,
  input  logic             s_val_i,
  output logic             s_rdy_o,
  output logic [7:0]       d_data_o,
  output logic             d_sof_o,
  output logic             d_eof_o,
  output logic             d_stb_o,
  input  logic [31:0]      c_res_i,
  input  logic [31:0]      c_exp_i,
  input  logic             c_val_i,
  output logic             st_val_o,
  output logic             st_ok_o,
  output logic [LEN_W-1:0] st_len_o,
  output logic [3:0]       st_err_o,
  output logic [LEN_W-1:0] frm_cnt_o,
  output logic [LEN_W-1:0] bad_cnt_o
);

  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_WAIT, S_REP
  } state_e;

  state_e state_q, state_d;

  logic             acc;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ok_q, ok_d;
  logic             abt_q, abt_d;
  logic             to_q, to_d;
  logic [7:0]       dd_q, dd_d;
  logic             dsof_q, dsof_d;
  logic             deof_q, deof_d;
  logic             dstb_q, dstb_d;
  logic             sv_q, sv_d;
  logic             sok_q, sok_d;
  logic [LEN_W-1:0] slen_q, slen_d;
  logic [3:0]       serr_q, serr_d;
  logic [3:0]       err;

  assign acc = s_val_i & s_rdy_o;

  always_ff @(posedge pclk_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (acc && s_sof_i)
          state_d = s_eof_i ? S_WAIT : S_RUN;
      S_RUN:
        if (acc && (s_sof_i || s_eof_i))
          state_d = S_WAIT;
      S_WAIT:
        if (c_val_i || tmo_q == TW'(TMO - 1))
          state_d = S_REP;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Error vector as reported; runt/giant judged on the final length.
  assign err = {abt_q, to_q,
                len_q > LEN_W'(MAX_LEN),
                len_q < LEN_W'(MIN_LEN)};

  always_comb begin
    s_rdy_o = (state_q == S_IDLE) || (state_q == S_RUN);
    tmo_d   = tmo_q;
    len_d   = len_q;
    ok_d    = ok_q;
    abt_d   = abt_q;
    to_d    = to_q;
    dd_d    = 8'h00;
    dsof_d  = 1'b0;
    deof_d  = 1'b0;
    dstb_d  = 1'b0;
    sv_d    = 1'b0;
    sok_d   = sok_q;
    slen_d  = slen_q;
    serr_d  = serr_q;
    unique case (state_q)
      S_IDLE: begin
        if (acc && s_sof_i) begin
          dstb_d = 1'b1;
          dsof_d = 1'b1;
          deof_d = s_eof_i;
          dd_d   = s_data_i;
          len_d  = LEN_W'(1);
          tmo_d  = '0;
          ok_d   = 1'b0;
          abt_d  = 1'b0;
          to_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (acc) begin
          dstb_d = 1'b1;
          if (s_sof_i) begin
            deof_d = 1'b1;
            abt_d  = 1'b1;
          end else begin
            deof_d = s_eof_i;
            dd_d   = s_data_i;
            if (len_q != '1) len_d = len_q + 1'b1;
          end
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (c_val_i) begin
          ok_d = (c_res_i == c_exp_i);
        end else if (tmo_q == TW'(TMO - 1)) begin
          ok_d = 1'b0;
          to_d = 1'b1;
        end
      end
      default: begin
        sv_d   = 1'b1;
        sok_d  = ok_q;
        slen_d = len_q;
        serr_d = err;
      end
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (!rstn_i) begin
      tmo_q  <= '0;
      len_q  <= '0;
      ok_q   <= 1'b0;
      abt_q  <= 1'b0;
      to_q   <= 1'b0;
      dd_q   <= 8'h00;
      dsof_q <= 1'b0;
      deof_q <= 1'b0;
      dstb_q <= 1'b0;
      sv_q   <= 1'b0;
      sok_q  <= 1'b0;
      slen_q <= '0;
      serr_q <= 4'h0;
    end else begin
      tmo_q  <= tmo_d;
      len_q  <= len_d;
      ok_q   <= ok_d;
      abt_q  <= abt_d;
      to_q   <= to_d;
      dd_q   <= dd_d;
      dsof_q <= dsof_d;
      deof_q <= deof_d;
      dstb_q <= dstb_d;
      sv_q   <= sv_d;
      sok_q  <= sok_d;
      slen_q <= slen_d;
      serr_q <= serr_d;
    end
  end

  assign d_data_o = dd_q;
  assign d_sof_o  = dsof_q;
  assign d_eof_o  = deof_q;
  assign d_stb_o  = dstb_q;
  assign st_val_o = sv_q;
  assign st_ok_o  = sok_q;
  assign st_len_o = slen_q;
  assign st_err_o = serr_q;

`ifdef FCS_CTL_STATS_EN
  logic [LEN_W-1:0] frm_q, frm_d;
  logic [LEN_W-1:0] bad_q, bad_d;

  always_comb begin
    frm_d = frm_q;
    bad_d = bad_q;
    if (state_q == S_REP) begin
      frm_d = frm_q + 1'b1;
      if (!ok_q || err != 4'h0) bad_d = bad_q + 1'b1;
    end
  end

  always_ff @(posedge pclk_i) begin
    if (!rstn_i) begin
      frm_q <= '0;
      bad_q <= '0;
    end else begin
      frm_q <= frm_d;
      bad_q <= bad_d;
    end
  end

  assign frm_cnt_o = frm_q;
  assign bad_cnt_o = bad_q;
`else
  assign frm_cnt_o = '0;
  assign bad_cnt_o = '0;
`endif

endmodule

// File: tb/tb_uut_1_fcs_ctl.sv
// Bench for uut_1_fcs_ctl: transaction-level model of strobes and status records,
// compared against the DUT every cycle, plus hand-derived literal checks.
module tb_uut_1_fcs_ctl;

  localparam int TMO   = 15;
  localparam int LEN_W = 16;

  logic        pclk = 1'b0;
  logic        rstn_i = 1'b0;
  logic [7:0]  s_data_i = '0;
  logic        s_sof_i = 1'b0, s_eof_i = 1'b0, s_val_i = 1'b0;
  logic        s_rdy_o;
  logic [7:0]  d_data_o;
  logic        d_sof_o, d_eof_o, d_stb_o;
  logic [31:0] c_res_i = '0, c_exp_i = '0;
  logic        c_val_i = 1'b0;
  logic        st_val_o, st_ok_o;
  logic [LEN_W-1:0] st_len_o, frm_cnt_o, bad_cnt_o;
  logic [3:0]  st_err_o;

  uut_1_fcs_ctl #(.MIN_LEN(64), .MAX_LEN(1518), .TMO(TMO), .LEN_W(LEN_W)) dut (
    .pclk_i(pclk), .rstn_i(rstn_i),
    .s_data_i(s_data_i), .s_sof_i(s_sof_i), .s_eof_i(s_eof_i),
    .s_val_i(s_val_i), .s_rdy_o(s_rdy_o),
    .d_data_o(d_data_o), .d_sof_o(d_sof_o), .d_eof_o(d_eof_o),
    .d_stb_o(d_stb_o),
    .c_res_i(c_res_i), .c_exp_i(c_exp_i), .c_val_i(c_val_i),
    .st_val_o(st_val_o), .st_ok_o(st_ok_o), .st_len_o(st_len_o),
    .st_err_o(st_err_o), .frm_cnt_o(frm_cnt_o), .bad_cnt_o(bad_cnt_o)
  );

  always #5 pclk = ~pclk;

  typedef struct { int cyc; logic [7:0] d; logic sof; logic eof; } stb_t;
  typedef struct { int cyc; logic ok; int len; logic [3:0] err; } st_t;

  stb_t sq[$];
  st_t  tq[$];
  int   cyc = 0;
  int   npass = 0, ntot = 0;
  bit   chk_en = 0;
  int   lo_from = 1, lo_to = 0;
  logic h_ok = 0;
  int   h_len = 0;
  logic [3:0] h_err = 0;
  logic [LEN_W-1:0] h_frm = 0, h_bad = 0;
  int   stb_cnt = 0, last_st = 0, eof_cyc = 0;

  always @(posedge pclk) cyc = cyc + 1;

  task automatic chk(string nm, longint act, longint exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge pclk) begin
    stb_t s;
    st_t  t;
    bit   es, et;
    if (chk_en) begin
      chk("s_rdy", s_rdy_o, !(cyc >= lo_from && cyc <= lo_to));
      es = sq.size() > 0 && sq[0].cyc == cyc;
      if (es) s = sq.pop_front();
      else    s = '{cyc, 8'h00, 1'b0, 1'b0};
      chk("d_stb", d_stb_o, es);
      chk("d_data", d_data_o, s.d);
      chk("d_sof", d_sof_o, s.sof);
      chk("d_eof", d_eof_o, s.eof);
      if (d_stb_o) stb_cnt++;
      et = tq.size() > 0 && tq[0].cyc == cyc;
      if (et) begin
        t = tq.pop_front();
        h_ok = t.ok; h_len = t.len; h_err = t.err;
`ifdef FCS_CTL_STATS_EN
        h_frm = h_frm + 1'b1;
        if (!t.ok || t.err != 0) h_bad = h_bad + 1'b1;
`endif
      end
      if (st_val_o) last_st = cyc;
      chk("st_val", st_val_o, et);
      chk("st_ok", st_ok_o, h_ok);
      chk("st_len", st_len_o, h_len);
      chk("st_err", st_err_o, h_err);
      chk("frm_cnt", frm_cnt_o, h_frm);
      chk("bad_cnt", bad_cnt_o, h_bad);
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic junk(int m);
    for (int i = 0; i < m; i++) begin
      s_val_i = 1; s_sof_i = 0; s_eof_i = 1'($urandom_range(1));
      s_data_i = 8'($urandom);
      tick();
    end
    s_val_i = 0; s_eof_i = 0;
  endtask

  // n bytes; abort_at>0 sends a sof after abort_at bytes; k = WAIT cycle of
  // the verdict (1..TMO), 0 = never; good = residue matches.
  task automatic send_frame(int n, int abort_at, int k, bit good, int gap);
    int len, e, sc;
    bit ab, tm;
    logic [31:0] r;
    ab  = abort_at > 0;
    len = ab ? abort_at : n;
    e   = cyc;
    for (int i = 0; i < len + int'(ab); i++) begin
      while (i > 0 && $urandom_range(99) < gap) begin
        s_val_i = 0;
        c_val_i = ($urandom_range(7) == 0);
        tick();
      end
      c_val_i  = 0;
      s_val_i  = 1;
      s_data_i = 8'($urandom);
      s_sof_i  = (i == 0) || (ab && i == len);
      s_eof_i  = !ab && i == n - 1;
      if (ab && i == len) sq.push_back('{cyc + 1, 8'h00, 1'b0, 1'b1});
      else sq.push_back('{cyc + 1, s_data_i, s_sof_i, s_eof_i});
      e = cyc;
      tick();
    end
    s_val_i = 0; s_sof_i = 0; s_eof_i = 0;
    tm = (k == 0);
    sc = e + (tm ? TMO : k) + 2;
    lo_from = e + 1;
    lo_to   = sc - 1;
    tq.push_back('{sc, !tm && good, len,
                   {ab, tm, len > 1518, len < 64}});
    while (cyc < sc) begin
      s_val_i  = 1'($urandom_range(1));
      s_sof_i  = 1'($urandom_range(1));
      s_data_i = 8'($urandom);
      r = $urandom;
      c_res_i = r;
      c_exp_i = good ? r : r ^ (32'h1 << $urandom_range(31));
      c_val_i = (k > 0 && cyc == e + k) ||
                (cyc == sc - 1 && $urandom_range(1) == 1);
      tick();
    end
    s_val_i = 0; s_sof_i = 0; c_val_i = 0;
    eof_cyc = e;
  endtask

  task automatic pin(string nm, bit ok, int len, logic [3:0] err, int lat);
    chk({nm, " ok"}, st_ok_o, ok);
    chk({nm, " len"}, st_len_o, len);
    chk({nm, " err"}, st_err_o, err);
    chk({nm, " lat"}, last_st - eof_cyc, lat);
  endtask

  int n, ab, k;

  initial begin
    repeat (3) tick();
    chk_en = 1;
    tick();
    chk("rst rdy", s_rdy_o, 1);
    chk("rst stb", d_stb_o, 0);
    rstn_i = 1;
    tick();

    stb_cnt = 0;
    send_frame(64, 0, 2, 1, 0);
    tick();
    pin("good64", 1, 64, 4'b0000, 4);
    chk("good64 strobes", stb_cnt, 64);
`ifdef FCS_CTL_STATS_EN
    chk("good64 frm", frm_cnt_o, 1);
    chk("good64 bad", bad_cnt_o, 0);
`endif

    send_frame(60, 0, 1, 0, 20);
    tick();
    pin("runt60", 0, 60, 4'b0001, 3);
`ifdef FCS_CTL_STATS_EN
    chk("runt60 bad", bad_cnt_o, 1);
`endif

    send_frame(100, 0, 0, 1, 10);
    tick();
    pin("tmo100", 0, 100, 4'b0100, TMO + 2);

    send_frame(20, 10, 3, 1, 0);
    tick();
    pin("abort", 1, 10, 4'b1001, 5);
    junk(3);
    send_frame(64, 0, TMO, 1, 0);
    tick();
    pin("after abort", 1, 64, 4'b0000, TMO + 2);

    stb_cnt = 0;
    junk(4);
    chk("idle junk strobes", stb_cnt, 0);
    send_frame(1, 0, 1, 1, 0);
    tick();
    pin("sofeof", 1, 1, 4'b0001, 3);

    for (int i = 0; i < 30; i++) begin
      s_val_i = 1; s_sof_i = (i == 0); s_eof_i = 0;
      s_data_i = 8'($urandom);
      sq.push_back('{cyc + 1, s_data_i, s_sof_i, 1'b0});
      tick();
    end
    s_val_i = 0; s_sof_i = 0;
    rstn_i = 0;
    tick();
    sq.delete(); tq.delete();
    h_ok = 0; h_len = 0; h_err = 0; h_frm = 0; h_bad = 0;
    lo_from = 1; lo_to = 0;
    rstn_i = 1;
    chk("midrst stb", d_stb_o, 0);
    chk("midrst rdy", s_rdy_o, 1);
    chk("midrst len", st_len_o, 0);
    repeat (20) tick();

    send_frame(1600, 0, 4, 1, 0);
    tick();
    pin("giant", 1, 1600, 4'b0010, 6);

    repeat (30) begin
      n  = $urandom_range(1, 140);
      ab = ($urandom_range(4) == 0) ? $urandom_range(1, n) : 0;
      k  = ($urandom_range(3) == 0) ? 0 : $urandom_range(1, TMO);
      if ($urandom_range(2) == 0) junk($urandom_range(1, 3));
      send_frame(n, ab, k, 1'($urandom_range(1)), 15);
    end

    repeat (5) tick();
    chk("queues drained", sq.size() + tq.size(), 0);
    chk_en = 0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", npass, ntot);
    $fatal(1);
  end

endmodule
